// File: rtl/touch_scan_ctrl.sv
// touch_scan_ctrl: pen-down detection, debounce and repeated X/Y conversion
// frames for an ADS7843-compatible ADC (8-bit serial mode), with per-set
// averaging and spread filtering.
// Ports:
//   sys_clk, iRST          clock, synchronous active-high reset
//   adc_penirq_n, adc_dout async ADC pen interrupt / serial data
//   adc_cs_n, adc_dclk,    ADC serial bus (chip select, clock, command data)
//   adc_din
//   x, y                   averaged coordinates
//   new_coord_r            one-cycle strobe when x/y update
//   transmit_en            high for the duration of a pen-down session
module touch_scan_ctrl #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned PEN_DLY    = 50000,
  parameter int unsigned SET_GAP    = 100000,
  parameter int unsigned N_AVG_LOG2 = 2,
  parameter int unsigned MAX_SPREAD = 8,
  parameter logic [7:0]  X_CMD      = 8'hD8,
  parameter logic [7:0]  Y_CMD      = 8'h98
) (
  input  logic       sys_clk,
  input  logic       iRST,
  input  logic       adc_penirq_n,
  input  logic       adc_dout,
  output logic       adc_cs_n,
  output logic       adc_dclk,
  output logic       adc_din,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       new_coord_r,
  output logic       transmit_en
);
  localparam int unsigned CNT_MAX   = (PEN_DLY > SET_GAP) ? PEN_DLY : SET_GAP;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W     = $clog2(CLK_DIV);
  localparam int unsigned IDX_W     = N_AVG_LOG2 + 1;
  localparam int unsigned SUM_W     = 8 + N_AVG_LOG2;
  // A frame is 51 slots of CLK_DIV cycles: slot 0 cs_n high, slot 1 lead-in,
  // slots 2..49 the 24 DCLK periods (even = low half, odd = high half),
  // slot 50 trailer.
  localparam int unsigned SLOT_LAST = 50;
  // High halves of DCLK periods 10..17 carry D7..D0.
  localparam int unsigned SMP_FIRST = 21;
  localparam int unsigned SMP_LAST  = 35;
  localparam logic [7:0]       SPREAD_MAX = 8'(MAX_SPREAD);
  localparam logic [IDX_W-1:0] N_PAIRS    = IDX_W'(1 << N_AVG_LOG2);

  typedef enum logic [2:0] {S_IDLE, S_DEBOUNCE, S_FRAME, S_CHECK, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rel_q, rel_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [5:0]       slot_q, slot_d;
  logic             axis_q, axis_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             frame_end_c, session_end_c;

  logic [1:0] pen_sync_q, dout_sync_q;
  logic       pen_s, dout_s;
  logic [7:0] shreg_q, xsamp_q;
  logic [SUM_W-1:0] xsum_q, ysum_q;
  logic [7:0] xmin_q, xmax_q, ymin_q, ymax_q;
  logic [7:0] xspread_c, yspread_c;
  logic       sample_en_c;
  logic       cs_n_d, dclk_d, din_d;
  logic       cs_n_q, dclk_q, din_q;
  logic [7:0] x_q, y_q;
  logic       new_coord_q, tx_q;
  logic [5:0] period_c;
  logic [7:0] cmd_c;

  // Two-flop synchronizers for the asynchronous ADC inputs.
  always_ff @(posedge sys_clk) begin
    if (iRST) begin
      pen_sync_q  <= 2'b11;
      dout_sync_q <= 2'b00;
    end else begin
      pen_sync_q  <= {pen_sync_q[0], adc_penirq_n};
      dout_sync_q <= {dout_sync_q[0], adc_dout};
    end
  end
  assign pen_s  = pen_sync_q[1];
  assign dout_s = dout_sync_q[1];

  // State register and sequencing counters.
  always_ff @(posedge sys_clk) begin
    if (iRST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rel_q   <= 1'b0;
      div_q   <= '0;
      slot_q  <= '0;
      axis_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      div_q   <= div_d;
      slot_q  <= slot_d;
      axis_q  <= axis_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rel_d         = rel_q;
    div_d         = div_q;
    slot_d        = slot_q;
    axis_d        = axis_q;
    idx_d         = idx_q;
    frame_end_c   = 1'b0;
    session_end_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!pen_s) begin
          state_d = S_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (pen_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(PEN_DLY - 1)) begin
          state_d = S_FRAME;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FRAME: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (slot_q == 6'(SLOT_LAST)) begin
            slot_d      = '0;
            frame_end_c = 1'b1;
            if (!axis_q) begin
              axis_d = 1'b1;
            end else begin
              axis_d = 1'b0;
              idx_d  = idx_q + IDX_W'(1);
              if (idx_d == N_PAIRS) begin
                idx_d   = '0;
                state_d = S_CHECK;
              end
            end
          end else begin
            slot_d = slot_q + 6'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_CHECK: begin
        state_d = S_GAP;
        cnt_d   = '0;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(SET_GAP - 1)) begin
          cnt_d = '0;
          if (!pen_s) begin
            rel_d   = 1'b0;
            state_d = S_FRAME;
          end else if (rel_q) begin
            // Second consecutive high sample: pen released.
            rel_d         = 1'b0;
            session_end_c = 1'b1;
            state_d       = S_IDLE;
          end else begin
            rel_d   = 1'b1;
            state_d = S_FRAME;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus outputs, decoded from the next state so the registered pins line up
  // with the state register.
  always_comb begin
    cs_n_d   = 1'b1;
    dclk_d   = 1'b0;
    din_d    = 1'b0;
    period_c = (slot_d - 6'd2) >> 1;
    cmd_c    = axis_d ? Y_CMD : X_CMD;
    if (state_d == S_FRAME && slot_d != 6'd0) begin
      cs_n_d = 1'b0;
      if (slot_d >= 6'd2 && slot_d <= 6'd49) begin
        dclk_d = slot_d[0];
        if (period_c < 6'd8) din_d = cmd_c[~period_c[2:0]];
      end
    end
  end

  // Sample at the last cycle of each data-bit high half.
  assign sample_en_c = (state_q == S_FRAME) && (div_q == DIV_W'(CLK_DIV - 1)) && slot_q[0] &&
                       (slot_q >= 6'(SMP_FIRST)) && (slot_q <= 6'(SMP_LAST));
  assign xspread_c = xmax_q - xmin_q;
  assign yspread_c = ymax_q - ymin_q;

  // Sample capture, set accumulation, filtering and output registers.
  always_ff @(posedge sys_clk) begin
    if (iRST) begin
      shreg_q     <= '0;
      xsamp_q     <= '0;
      xsum_q      <= '0;
      ysum_q      <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      new_coord_q <= 1'b0;
      tx_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      dclk_q      <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      cs_n_q <= cs_n_d;
      dclk_q <= dclk_d;
      din_q  <= din_d;
      if (sample_en_c) shreg_q <= {shreg_q[6:0], dout_s};
      if (frame_end_c && !axis_q) xsamp_q <= shreg_q;
      if (frame_end_c && axis_q) begin
        if (idx_q == '0) begin
          xsum_q <= SUM_W'(xsamp_q);
          ysum_q <= SUM_W'(shreg_q);
          xmin_q <= xsamp_q;
          xmax_q <= xsamp_q;
          ymin_q <= shreg_q;
          ymax_q <= shreg_q;
        end else begin
          xsum_q <= xsum_q + SUM_W'(xsamp_q);
          ysum_q <= ysum_q + SUM_W'(shreg_q);
          if (xsamp_q < xmin_q) xmin_q <= xsamp_q;
          if (xsamp_q > xmax_q) xmax_q <= xsamp_q;
          if (shreg_q < ymin_q) ymin_q <= shreg_q;
          if (shreg_q > ymax_q) ymax_q <= shreg_q;
        end
      end
      new_coord_q <= 1'b0;
      if (state_q == S_CHECK && xspread_c <= SPREAD_MAX && yspread_c <= SPREAD_MAX) begin
        x_q         <= 8'(xsum_q >> N_AVG_LOG2);
        y_q         <= 8'(ysum_q >> N_AVG_LOG2);
        new_coord_q <= 1'b1;
      end
      if (session_end_c)    tx_q <= 1'b0;
      else if (new_coord_q) tx_q <= 1'b1;
    end
  end

  assign adc_cs_n    = cs_n_q;
  assign adc_dclk    = dclk_q;
  assign adc_din     = din_q;
  assign x           = x_q;
  assign y           = y_q;
  assign new_coord_r = new_coord_q;
  assign transmit_en = tx_q;
endmodule

// File: tb/tb_touch_scan_ctrl.sv
// Bench for touch_scan_ctrl: ADC bus model driving sample values by command,
// set-level reference model for averaging/filtering, scenario tasks.
module tb_touch_scan_ctrl;
  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned PEN_DLY    = 10;
  localparam int unsigned SET_GAP    = 20;
  localparam int unsigned N_AVG_LOG2 = 2;
  localparam int unsigned MAX_SPREAD = 8;
  localparam int FRAME_LEN  = 50 * CLK_DIV;
  localparam int SET_PERIOD = 4 * 2 * 51 * CLK_DIV + 1 + SET_GAP;

  logic       sys_clk = 1'b0;
  logic       iRST = 1'b1;
  logic       adc_penirq_n = 1'b1;
  logic       adc_dout = 1'b0;
  logic       adc_cs_n, adc_dclk, adc_din;
  logic [7:0] x, y;
  logic       new_coord_r, transmit_en;

  int total = 0;
  int bad = 0;

  logic [7:0] xs[4];
  logic [7:0] ys[4];
  logic [7:0] exp_x = 8'h00;
  logic [7:0] exp_y = 8'h00;

  // Observations collected by the ADC model.
  int frames_done = 0, falls = 0, strobes = 0, rise_cnt = 0;
  int len_err = 0, gap_err = 0, width_err = 0, last_len = 0;
  logic [7:0] cmd_q[$];

  touch_scan_ctrl #(
    .CLK_DIV(CLK_DIV), .PEN_DLY(PEN_DLY), .SET_GAP(SET_GAP),
    .N_AVG_LOG2(N_AVG_LOG2), .MAX_SPREAD(MAX_SPREAD),
    .X_CMD(8'hD8), .Y_CMD(8'h98)
  ) dut (
    .sys_clk(sys_clk), .iRST(iRST), .adc_penirq_n(adc_penirq_n), .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n), .adc_dclk(adc_dclk), .adc_din(adc_din),
    .x(x), .y(y), .new_coord_r(new_coord_r), .transmit_en(transmit_en)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ADC model: captures the command on DCLK rises, drives D7..D0 from the
  // falls that start periods 10..17, measures frame and inter-frame lengths.
  initial begin : adc_model
    logic pc, pd, ps;
    int lo_len, hi_len, fall_hi, xp, yp;
    logic [7:0] cmd, v;
    pc = 1; pd = 0; ps = 0; lo_len = 0; hi_len = 0; fall_hi = 0; xp = 0; yp = 0;
    cmd = 0; v = 0;
    forever begin
      @(negedge sys_clk);
      if (iRST) begin
        pc = 1; pd = 0; ps = 0; rise_cnt = 0; xp = 0; yp = 0; lo_len = 0; hi_len = 0;
        adc_dout = 1'b0;
      end else begin
        if (pc && !adc_cs_n) begin
          falls++; rise_cnt = 0; cmd = 0; lo_len = 0; fall_hi = hi_len;
        end
        if (!pc && adc_cs_n) begin
          frames_done++; last_len = lo_len; cmd_q.push_back(cmd);
          if (lo_len != FRAME_LEN) len_err++;
          if (cmd == 8'h98 && fall_hi != CLK_DIV) gap_err++;
          if (cmd == 8'hD8) xp++; else yp++;
          hi_len = 1;
        end else if (adc_cs_n) hi_len++;
        if (!adc_cs_n) lo_len++;
        if (!adc_cs_n && !pd && adc_dclk) begin
          rise_cnt++;
          if (rise_cnt <= 8) cmd = {cmd[6:0], adc_din};
        end
        if (!adc_cs_n && pd && !adc_dclk) begin
          if (rise_cnt >= 9 && rise_cnt <= 16) begin
            v = (cmd == 8'hD8) ? xs[xp % 4] : ys[yp % 4];
            adc_dout = v[3'(16 - rise_cnt)];
          end else adc_dout = 1'b0;
        end
        if (new_coord_r) begin
          strobes++;
          if (ps) width_err++;
        end
        ps = new_coord_r; pc = adc_cs_n; pd = adc_dclk;
      end
    end
  end

  // Reference: a set is accepted when max-min per axis is within MAX_SPREAD.
  function automatic bit ref_ok(input logic [7:0] v[4]);
    int mx, mn;
    mx = v[0]; mn = v[0];
    foreach (v[i]) begin
      if (int'(v[i]) > mx) mx = v[i];
      if (int'(v[i]) < mn) mn = v[i];
    end
    return (mx - mn) <= int'(MAX_SPREAD);
  endfunction

  function automatic logic [7:0] ref_avg(input logic [7:0] v[4]);
    int s;
    s = 0;
    foreach (v[i]) s += v[i];
    return 8'(s / 4);
  endfunction

  task automatic tick();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
    xs[0] = a0; xs[1] = a1; xs[2] = a2; xs[3] = a3;
    ys[0] = b0; ys[1] = b1; ys[2] = b2; ys[3] = b3;
  endtask

  // Runs one set to completion and checks strobe/x/y against the reference.
  task automatic run_set(input string name);
    int target, base_str, n;
    bit ok;
    target = frames_done + 8; base_str = strobes;
    ok = ref_ok(xs) && ref_ok(ys);
    if (ok) begin exp_x = ref_avg(xs); exp_y = ref_avg(ys); end
    n = 0;
    while (frames_done < target && n < 3000) begin tick(); n++; end
    total++;
    if (frames_done < target) begin
      bad++; $display("FAIL %s_timeout frames=%0d want=%0d", name, frames_done, target);
    end
    repeat (3) tick();
    total++;
    if ((strobes - base_str) != (ok ? 1 : 0)) begin
      bad++; $display("FAIL %s_strobe got=%0d want=%0d", name, strobes - base_str, ok ? 1 : 0);
    end
    total++;
    if (x !== exp_x) begin bad++; $display("FAIL %s_x got=%h want=%h", name, x, exp_x); end
    total++;
    if (y !== exp_y) begin bad++; $display("FAIL %s_y got=%h want=%h", name, y, exp_y); end
    total++;
    if (transmit_en !== 1'b1) begin
      bad++; $display("FAIL %s_tx got=%b want=1", name, transmit_en);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    total++;
    if ({adc_cs_n, adc_dclk, adc_din, new_coord_r, transmit_en} !== 5'b10000) begin
      bad++; $display("FAIL %s_ctl got=%b want=10000", name,
                      {adc_cs_n, adc_dclk, adc_din, new_coord_r, transmit_en});
    end
    total++;
    if (x !== 8'h00 || y !== 8'h00) begin
      bad++; $display("FAIL %s_xy got=%h/%h want=00/00", name, x, y);
    end
  endtask

  task automatic test_reset();
    iRST = 1'b1; adc_penirq_n = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    iRST = 1'b0;
    repeat (5) tick();
    total++;
    if (adc_cs_n !== 1'b1) begin bad++; $display("FAIL reset_idle cs_n got=%b want=1", adc_cs_n); end
  endtask

  task automatic test_basic();
    int n;
    load(8'h40, 8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h80);
    adc_penirq_n = 1'b0;
    n = 0;
    while (new_coord_r !== 1'b1 && n < 3000) begin tick(); n++; end
    total++;
    if (new_coord_r !== 1'b1) begin bad++; $display("FAIL basic_strobe_timeout got=0 want=1"); end
    exp_x = 8'h40; exp_y = 8'h80;
    total++;
    if (x !== exp_x || y !== exp_y) begin
      bad++; $display("FAIL basic_xy got=%h/%h want=40/80", x, y);
    end
    total++;
    if (transmit_en !== 1'b0) begin bad++; $display("FAIL basic_tx_early got=%b want=0", transmit_en); end
    tick();
    total++;
    if (new_coord_r !== 1'b0 || transmit_en !== 1'b1) begin
      bad++; $display("FAIL basic_tx_rise strobe=%b tx=%b want strobe=0 tx=1", new_coord_r, transmit_en);
    end
    total++;
    if (cmd_q.size() < 2 || cmd_q[0] !== 8'hD8 || cmd_q[1] !== 8'h98) begin
      bad++; $display("FAIL basic_cmd got=%h,%h want=d8,98", cmd_q[0], cmd_q[1]);
    end
    total++;
    if (last_len != FRAME_LEN || len_err != 0) begin
      bad++; $display("FAIL basic_frame_len got=%0d errs=%0d want=%0d", last_len, len_err, FRAME_LEN);
    end
    total++;
    if (gap_err != 0) begin bad++; $display("FAIL basic_cs_gap errs=%0d want=0", gap_err); end
    n = 1;
    while (new_coord_r !== 1'b1 && n < 3000) begin tick(); n++; end
    total++;
    if (n != SET_PERIOD) begin bad++; $display("FAIL basic_set_period got=%0d want=%0d", n, SET_PERIOD); end
  endtask

  task automatic test_average();
    load(8'h10, 8'h12, 8'h14, 8'h17, 8'h20, 8'h20, 8'h20, 8'h20);
    run_set("average");
    total++;
    if (x !== 8'h13 || y !== 8'h20) begin bad++; $display("FAIL average_abs got=%h/%h want=13/20", x, y); end
  endtask

  task automatic test_spread();
    load(8'h10, 8'h10, 8'h10, 8'h19, 8'h20, 8'h20, 8'h20, 8'h20);
    run_set("spread");
    total++;
    if (x !== 8'h13 || y !== 8'h20) begin bad++; $display("FAIL spread_hold got=%h/%h want=13/20", x, y); end
  endtask

  task automatic test_random();
    int base, sp;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 4; i++) begin
        base = $urandom_range(32, 200); sp = $urandom_range(0, 12);
        if (i == 0) begin
          xs[0] = 8'(base);
          ys[0] = 8'($urandom_range(32, 200));
        end else begin
          xs[i] = 8'(int'(xs[0]) + $urandom_range(0, sp));
          ys[i] = 8'(int'(ys[0]) + $urandom_range(0, sp));
        end
      end
      run_set("random");
    end
    total++;
    if (width_err != 0) begin bad++; $display("FAIL random_strobe_width errs=%0d want=0", width_err); end
  endtask

  task automatic test_release();
    int f0;
    load(8'h50, 8'h51, 8'h52, 8'h53, 8'h60, 8'h61, 8'h62, 8'h63);
    adc_penirq_n = 1'b1;
    run_set("release_one_high");
    adc_penirq_n = 1'b0;
    run_set("release_low_again");
    adc_penirq_n = 1'b1;
    run_set("release_first_high");
    repeat (16) tick();
    total++;
    if (transmit_en !== 1'b1) begin bad++; $display("FAIL release_tx_early got=%b want=1", transmit_en); end
    repeat (4) tick();
    total++;
    if (transmit_en !== 1'b0) begin bad++; $display("FAIL release_tx_fall got=%b want=0", transmit_en); end
    f0 = falls;
    repeat (300) tick();
    total++;
    if (falls != f0 || adc_cs_n !== 1'b1) begin
      bad++; $display("FAIL release_idle falls=%0d want=%0d cs_n=%b", falls, f0, adc_cs_n);
    end
  endtask

  task automatic test_glitch();
    int f0;
    f0 = falls;
    adc_penirq_n = 1'b0;
    repeat (8) tick();
    adc_penirq_n = 1'b1;
    repeat (100) tick();
    total++;
    if (falls != f0 || adc_cs_n !== 1'b1) begin
      bad++; $display("FAIL glitch falls=%0d want=%0d cs_n=%b", falls, f0, adc_cs_n);
    end
  endtask

  task automatic test_midreset();
    int f0, n;
    load(8'h70, 8'h72, 8'h74, 8'h76, 8'h30, 8'h31, 8'h32, 8'h33);
    f0 = falls;
    adc_penirq_n = 1'b0;
    n = 0;
    while ((falls == f0 || rise_cnt < 12) && n < 500) begin tick(); n++; end
    total++;
    if (rise_cnt != 12) begin bad++; $display("FAIL midreset_reach got=%0d want=12", rise_cnt); end
    iRST = 1'b1;
    tick();
    exp_x = 8'h00; exp_y = 8'h00;
    check_idle_outputs("midreset");
    tick();
    iRST = 1'b0;
    f0 = falls; n = 0;
    while (falls == f0 && n < 300) begin tick(); n++; end
    total++;
    if (falls == f0 || n < int'(PEN_DLY)) begin
      bad++; $display("FAIL midreset_restart delay=%0d want>=%0d", n, PEN_DLY);
    end
    run_set("midreset_set");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_average();
    test_spread();
    test_random();
    test_release();
    test_glitch();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
